// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and sibling control blocks.
// State encoding and a constant-safe clog2 helper.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Never returns 0 so index ports stay at least one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from last+1, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_onehot_o,
    output logic [IW-1:0]      gnt_idx_o,
    output logic               any_o
);

    int         idx;
    logic [IW-1:0] idx_l;
    logic       found;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        found        = 1'b0;
        idx          = 0;
        idx_l        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_i) + k) % NUM_REQ;
            idx_l = IW'(idx);
            if (!found && req_i[idx_l]) begin
                found        = 1'b1;
                gnt_onehot_o = NUM_REQ'(1) << idx;
                gnt_idx_o    = idx_l;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// One-entry hold register, fifo_full back-pressure, stop freeze, sticky stall error.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DW        = 32,
    parameter int MAX_STALL = 15
) (
    input  logic                    clk,
    input  logic                    rst1_n_sync,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    stop,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DW-1:0]           fifo_wr_data,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    stall_err,
    input  logic                    err_clr
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = 9;
    localparam logic [CW-1:0] STALL_LIM = CW'(MAX_STALL + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_i        (req_valid),
        .last_i       (gid_q),
        .gnt_onehot_o (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .any_o        (gnt_any)
    );

    always_ff @(posedge clk or negedge rst1_n_sync) begin
        if (!rst1_n_sync) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        gid_d      = gid_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        if (err_clr) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && gnt_any) begin
                    req_ready = gnt_oh;
                    hold_d    = req_data[gnt_idx*DW +: DW];
                    gid_d     = gnt_idx;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    if (cnt_q != STALL_LIM) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Placed after the clear so a same-cycle set wins.
                    if (cnt_d == STALL_LIM) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_wr_data = hold_q;
    assign grant_id     = gid_q;
    assign busy         = (state_q == ST_SEND);
    assign stall_err    = err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter.
// Directed scenarios followed by a randomized run against a queue model.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst1_n_sync;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        stop;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [0:0]  grant_id;
    logic        busy;
    logic        stall_err;
    logic        err_clr;

    int n_cmp;
    int n_bad;

    fifo_write_arbiter #(
        .NUM_REQ   (2),
        .DW        (32),
        .MAX_STALL (15)
    ) dut (
        .clk          (clk),
        .rst1_n_sync  (rst1_n_sync),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stop         (stop),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .stall_err    (stall_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    logic [31:0] w_exp;
    int          g0, g1, exp_i;

    logic [31:0] rq_d [2];
    logic [1:0]  rq_v;
    logic [31:0] pend [$];
    int          last, run, w, full_left;
    bit          err_m, set_m, clr_m, full_m, stop_m, wr_m;
    logic [1:0]  rdy_m;

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst1_n_sync = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        stop        = 1'b0;
        fifo_full   = 1'b0;
        err_clr     = 1'b0;
        #2;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_err), 64'd0);
        tick();
        tick();
        rst1_n_sync = 1'b1;

        // Single requester
        req_valid     = 2'b01;
        req_data[31:0] = 32'hA5A5_0001;
        settle();
        check("single_ready", 64'(req_ready), 64'd1);
        check("single_busy0", 64'(busy), 64'd0);
        tick();
        req_valid = 2'b00;
        settle();
        check("single_wr_en", 64'(fifo_wr_en), 64'd1);
        check("single_data", 64'(fifo_wr_data), 64'hA5A5_0001);
        check("single_busy1", 64'(busy), 64'd1);
        check("single_gid", 64'(grant_id), 64'd0);
        tick();
        settle();
        check("single_busy2", 64'(busy), 64'd0);
        check("single_wr_off", 64'(fifo_wr_en), 64'd0);
        tick();

        // Fairness: both valid, 12 words
        g0 = 0;
        g1 = 0;
        req_valid       = 2'b11;
        req_data[31:0]  = 32'h1000_0000;
        req_data[63:32] = 32'h2000_0000;
        for (int c = 0; c < 24; c++) begin
            settle();
            if ((c % 2) == 0) begin
                exp_i = ((c / 2) % 2 == 0) ? 1 : 0;
                check("fair_ready", 64'(req_ready), 64'(2'b01 << exp_i));
                check("fair_no_wr", 64'(fifo_wr_en), 64'd0);
                if (req_ready[0]) g0++;
                if (req_ready[1]) g1++;
                w_exp = req_data[exp_i*32 +: 32];
                tick();
                req_data[exp_i*32 +: 32] = w_exp + 32'd1;
            end else begin
                check("fair_wr_en", 64'(fifo_wr_en), 64'd1);
                check("fair_data", 64'(fifo_wr_data), 64'(w_exp));
                check("fair_no_rdy", 64'(req_ready), 64'd0);
                tick();
            end
        end
        check("fair_cnt0", 64'(g0), 64'd6);
        check("fair_cnt1", 64'(g1), 64'd6);
        req_valid = 2'b00;

        // Back-pressure, 5 full cycles
        req_valid      = 2'b01;
        req_data[31:0] = 32'h1234_5678;
        settle();
        check("bp_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_wr_off", 64'(fifo_wr_en), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        check("bp_wr_en", 64'(fifo_wr_en), 64'd1);
        check("bp_data", 64'(fifo_wr_data), 64'h1234_5678);
        check("bp_stall", 64'(stall_err), 64'd0);
        tick();

        // Stall error with err_clr colliding on the setting cycle
        req_valid      = 2'b01;
        req_data[31:0] = 32'hDEAD_0001;
        settle();
        check("st_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        fifo_full = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            err_clr = (c == 16);
            settle();
            check("st_wr_off", 64'(fifo_wr_en), 64'd0);
            check("st_not_yet", 64'(stall_err), 64'd0);
            tick();
        end
        err_clr = 1'b0;
        settle();
        check("st_set_wins", 64'(stall_err), 64'd1);
        check("st_busy", 64'(busy), 64'd1);
        tick();
        fifo_full = 1'b0;
        settle();
        check("st_drain_wr", 64'(fifo_wr_en), 64'd1);
        check("st_drain_data", 64'(fifo_wr_data), 64'hDEAD_0001);
        tick();
        settle();
        check("st_sticky", 64'(stall_err), 64'd1);
        tick();
        err_clr = 1'b1;
        settle();
        tick();
        err_clr = 1'b0;
        settle();
        check("st_cleared", 64'(stall_err), 64'd0);
        tick();

        // Stop while in SEND
        req_valid       = 2'b11;
        req_data[31:0]  = 32'h5A00_0000;
        req_data[63:32] = 32'h5A00_0001;
        settle();
        check("stop_first", 64'(req_ready), 64'd2);
        tick();
        req_data[63:32] = 32'h5A00_0002;
        stop = 1'b1;
        settle();
        check("stop_pend_wr", 64'(fifo_wr_en), 64'd1);
        check("stop_pend_dat", 64'(fifo_wr_data), 64'h5A00_0001);
        check("stop_pend_rdy", 64'(req_ready), 64'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stop_no_rdy", 64'(req_ready), 64'd0);
            check("stop_no_wr", 64'(fifo_wr_en), 64'd0);
            tick();
        end
        stop = 1'b0;
        settle();
        check("stop_release", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b10;
        settle();
        check("stop_rel_data", 64'(fifo_wr_data), 64'h5A00_0000);
        tick();
        settle();
        check("stop_next", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        tick();

        // Reset mid-SEND
        req_valid      = 2'b01;
        req_data[31:0] = 32'hBAD0_BAD0;
        settle();
        tick();
        req_valid = 2'b00;
        fifo_full = 1'b1;
        settle();
        check("rs_busy_pre", 64'(busy), 64'd1);
        rst1_n_sync = 1'b0;
        #1;
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rs_data", 64'(fifo_wr_data), 64'd0);
        check("rs_grant", 64'(grant_id), 64'd0);
        check("rs_stall", 64'(stall_err), 64'd0);
        tick();
        rst1_n_sync = 1'b1;
        fifo_full   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("rs_no_stale", 64'(fifo_wr_en), 64'd0);
            tick();
        end

        // Randomized run against the queue model
        rst1_n_sync = 1'b0;
        tick();
        rst1_n_sync = 1'b1;
        rq_v      = '0;
        rq_d[0]   = '0;
        rq_d[1]   = '0;
        last      = 0;
        run       = 0;
        err_m     = 1'b0;
        full_left = 0;
        pend.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            stop_m = ($urandom_range(0, 9) == 0);
            clr_m  = ($urandom_range(0, 29) == 0);
            if (full_left > 0) begin
                full_m = 1'b1;
                full_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                full_m    = 1'b1;
                full_left = $urandom_range(10, 22);
            end else begin
                full_m = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (!rq_v[i] && ($urandom_range(0, 1) == 1)) begin
                    rq_v[i] = 1'b1;
                    rq_d[i] = $urandom;
                end
            end
            req_valid       = rq_v;
            req_data[31:0]  = rq_d[0];
            req_data[63:32] = rq_d[1];
            stop            = stop_m;
            fifo_full       = full_m;
            err_clr         = clr_m;

            rdy_m = '0;
            wr_m  = 1'b0;
            w     = -1;
            if (pend.size() == 0) begin
                if (!stop_m && (rq_v != 2'b00)) begin
                    for (int k = 1; k <= 2; k++) begin
                        if (w < 0 && rq_v[(last + k) % 2]) w = (last + k) % 2;
                    end
                    rdy_m = 2'b01 << w;
                end
            end else begin
                wr_m = !full_m;
            end

            settle();
            check("rnd_ready", 64'(req_ready), 64'(rdy_m));
            check("rnd_wr_en", 64'(fifo_wr_en), 64'(wr_m));
            if (wr_m) check("rnd_data", 64'(fifo_wr_data), 64'(pend[0]));
            check("rnd_busy", 64'(busy), 64'(pend.size() != 0));
            check("rnd_grant", 64'(grant_id), 64'(last));
            check("rnd_stall", 64'(stall_err), 64'(err_m));
            tick();

            set_m = 1'b0;
            if (pend.size() != 0) begin
                if (wr_m) begin
                    void'(pend.pop_front());
                    run = 0;
                end else begin
                    run++;
                    set_m = (run >= 16);
                end
            end
            if (w >= 0) begin
                pend.push_back(rq_d[w]);
                last    = w;
                rq_v[w] = 1'b0;
            end
            if (set_m) err_m = 1'b1;
            else if (clr_m) err_m = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
